debug_readout_sequencer: RTL and testbench

DEBUG_READOUT_SEQUENCER -- requirements
Module: debug_readout_sequencer

---
 rtl/debug_pkg.sv | 49 ++++
 rtl/debug_latch_word_mux.sv | 37 +++
 rtl/debug_readout_sequencer.sv | 139 +++++++++++++
 tb/tb_debug_readout_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants, request codes and state encodings for the debug readout path.
// Also holds the request-code decoder used by the sequencer.
package debug_pkg;

    localparam int unsigned NB_FRAME = 32;
    localparam int unsigned NB_LATCH = 96;
    localparam int unsigned N_GROUPS = 8;

    localparam logic [5:0] REQ_NONE        = 6'h3F;
    localparam logic [5:0] REQ_DMEM        = 6'h20;
    localparam logic [5:0] REQ_IMEM        = 6'h21;
    localparam logic [5:0] REQ_PC          = 6'h22;
    localparam logic [5:0] REQ_LATCH_FIRST = 6'h24;
    localparam logic [5:0] REQ_LATCH_LAST  = 6'h2B;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StIssue,
        StXfer,
        StEod
    } state_t;

    typedef enum logic [2:0] {
        KindNone,
        KindRf,
        KindDmem,
        KindImem,
        KindPc,
        KindLatch
    } req_kind_t;

    // Codes 0rrrrr address the register file; everything not listed is ignored.
    function automatic req_kind_t decode_request(input logic [5:0] code);
        if (!code[5]) begin
            return KindRf;
        end else if (code == REQ_DMEM) begin
            return KindDmem;
        end else if (code == REQ_IMEM) begin
            return KindImem;
        end else if (code == REQ_PC) begin
            return KindPc;
        end else if (code >= REQ_LATCH_FIRST && code <= REQ_LATCH_LAST) begin
            return KindLatch;
        end
        return KindNone;
    endfunction

endpackage

// File: rtl/debug_latch_word_mux.sv
// Selects one NB_FRAME word out of the flat latch-group bus.
// Word 0 is the most significant word of the selected group.
module debug_latch_word_mux
    import debug_pkg::*;
#(
    parameter int unsigned NB_FRAME = debug_pkg::NB_FRAME,
    parameter int unsigned NB_LATCH = debug_pkg::NB_LATCH
) (
    input  logic [N_GROUPS*NB_LATCH-1:0] latch_data,
    input  logic [2:0]                   group,
    input  logic [1:0]                   word_idx,
    output logic [NB_FRAME-1:0]          word
);

    localparam int unsigned WORDS_PER_GROUP = NB_LATCH / NB_FRAME;

    logic [NB_LATCH-1:0] group_bits;

    always_comb begin
        group_bits = '0;
        for (int g = 0; g < int'(N_GROUPS); g++) begin
            if (group == 3'(g)) begin
                group_bits = latch_data[g*NB_LATCH +: NB_LATCH];
            end
        end
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < int'(WORDS_PER_GROUP); k++) begin
            if (word_idx == 2'(k)) begin
                word = group_bits[NB_LATCH-1-k*NB_FRAME -: NB_FRAME];
            end
        end
    end

endmodule

// File: rtl/debug_readout_sequencer.sv
// Serialises debug readouts (registers, memory, PC, latch groups) into frames,
// borrowing the register-file/memory ports by stalling the pipeline when needed.
module debug_readout_sequencer
    import debug_pkg::*;
#(
    parameter int unsigned NB_FRAME    = debug_pkg::NB_FRAME,
    parameter int unsigned NB_LATCH    = debug_pkg::NB_LATCH,
    parameter int unsigned NB_MEM_ADDR = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [5:0]               i_request_select,
    input  logic [NB_MEM_ADDR-1:0]   i_mem_addr,
    input  logic                     i_pipe_idle,
    input  logic [NB_FRAME-1:0]      i_pc,
    input  logic [8*NB_LATCH-1:0]    i_latch_data,
    input  logic [NB_FRAME-1:0]      i_rf_data,
    input  logic [NB_FRAME-1:0]      i_mem_data,
    output logic [4:0]               o_rf_addr,
    output logic                     o_rf_re,
    output logic [NB_MEM_ADDR-1:0]   o_mem_addr,
    output logic                     o_mem_space,
    output logic                     o_mem_re,
    output logic                     o_stall,
    output logic [NB_FRAME-1:0]      o_frame,
    output logic                     o_frame_valid,
    output logic                     o_eod,
    output logic                     o_busy
);

    localparam int unsigned WORDS_PER_GROUP = NB_LATCH / NB_FRAME;

    state_t              state;
    req_kind_t           kind;
    req_kind_t           req_kind;
    logic [2:0]          group;
    logic [1:0]          word_idx;
    logic [1:0]          word_count;
    logic [NB_FRAME-1:0] latch_word;

    assign req_kind = decode_request(i_request_select);

    debug_latch_word_mux #(
        .NB_FRAME (NB_FRAME),
        .NB_LATCH (NB_LATCH)
    ) u_latch_word_mux (
        .latch_data (i_latch_data),
        .group      (group),
        .word_idx   (word_idx),
        .word       (latch_word)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= StIdle;
            kind          <= KindNone;
            group         <= '0;
            word_idx      <= '0;
            word_count    <= '0;
            o_rf_addr     <= '0;
            o_rf_re       <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_space   <= 1'b0;
            o_mem_re      <= 1'b0;
            o_stall       <= 1'b0;
            o_frame_valid <= 1'b0;
            o_eod         <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_rf_re       <= 1'b0;
            o_mem_re      <= 1'b0;
            o_frame_valid <= 1'b0;
            o_eod         <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_kind != KindNone) begin
                        kind        <= req_kind;
                        group       <= 3'(i_request_select[3:0] - 4'd4);
                        word_idx    <= '0;
                        word_count  <= (req_kind == KindLatch) ? 2'(WORDS_PER_GROUP) : 2'd1;
                        o_rf_addr   <= i_request_select[4:0];
                        o_mem_addr  <= i_mem_addr;
                        o_mem_space <= (req_kind == KindImem);
                        o_busy      <= 1'b1;
                        if (req_kind == KindPc || req_kind == KindLatch) begin
                            state         <= StXfer;
                            o_frame_valid <= 1'b1;
                        end else begin
                            state   <= StGrant;
                            o_stall <= 1'b1;
                        end
                    end
                end
                StGrant: begin
                    if (i_pipe_idle) begin
                        state    <= StIssue;
                        o_rf_re  <= (kind == KindRf);
                        o_mem_re <= (kind != KindRf);
                    end
                end
                StIssue: begin
                    state         <= StXfer;
                    o_frame_valid <= 1'b1;
                end
                StXfer: begin
                    if (word_idx == word_count - 2'd1) begin
                        state    <= StEod;
                        word_idx <= '0;
                        o_eod    <= 1'b1;
                        o_stall  <= 1'b0;
                    end else begin
                        word_idx      <= word_idx + 2'd1;
                        o_frame_valid <= 1'b1;
                    end
                end
                StEod: begin
                    state  <= StIdle;
                    o_busy <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Read data arrives combinationally in the XFER cycle, one cycle after the strobe.
    always_comb begin
        o_frame = '0;
        if (state == StXfer) begin
            unique case (kind)
                KindRf:             o_frame = i_rf_data;
                KindDmem, KindImem: o_frame = i_mem_data;
                KindPc:             o_frame = i_pc;
                KindLatch:          o_frame = latch_word;
                default:            o_frame = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_readout_sequencer.sv
// Directed bench for debug_readout_sequencer with small register-file and memory models.
module tb_debug_readout_sequencer;

    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    request_select;
    logic [15:0]   mem_addr;
    logic          pipe_idle;
    logic [31:0]   pc;
    logic [767:0]  latch_data;
    logic [31:0]   rf_data;
    logic [31:0]   mem_data;
    logic [4:0]    rf_addr;
    logic          rf_re;
    logic [15:0]   mem_addr_out;
    logic          mem_space;
    logic          mem_re;
    logic          stall;
    logic [31:0]   frame;
    logic          frame_valid;
    logic          eod;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_frames;
    int n_eods;

    always #5 clock = ~clock;

    debug_readout_sequencer dut (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_request_select (request_select),
        .i_mem_addr       (mem_addr),
        .i_pipe_idle      (pipe_idle),
        .i_pc             (pc),
        .i_latch_data     (latch_data),
        .i_rf_data        (rf_data),
        .i_mem_data       (mem_data),
        .o_rf_addr        (rf_addr),
        .o_rf_re          (rf_re),
        .o_mem_addr       (mem_addr_out),
        .o_mem_space      (mem_space),
        .o_mem_re         (mem_re),
        .o_stall          (stall),
        .o_frame          (frame),
        .o_frame_valid    (frame_valid),
        .o_eod            (eod),
        .o_busy           (busy)
    );

    // Register file holds 0x12345678 at index 7; memory returns {space, addr}.
    always @(posedge clock) begin
        rf_data  <= (rf_re && rf_addr == 5'd7) ? 32'h1234_5678 : 32'hDEAD_BEEF;
        mem_data <= mem_re ? {15'h0, mem_space, mem_addr_out} : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic count_transfer(input int cycles);
        n_frames = 0;
        n_eods   = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            request_select = 6'h3F;
            if (frame_valid) n_frames++;
            if (eod) n_eods++;
            check("valid_eod_excl", {63'h0, frame_valid & eod}, 64'h0);
        end
    endtask

    initial begin
        reset          = 1'b1;
        request_select = 6'h3F;
        mem_addr       = 16'h0;
        pipe_idle      = 1'b1;
        pc             = 32'h0;
        for (int g = 0; g < 8; g++) begin
            latch_data[g*96 +: 96] = {8'(g), 24'h111111, 8'(g), 24'h222222, 8'(g), 24'h333333};
        end
        latch_data[96 +: 96] = 96'hAAAA0001_BBBB0002_CCCC0003;
        step();
        step();
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_stall", {63'h0, stall}, 64'h0);
        check("rst_valid", {63'h0, frame_valid}, 64'h0);
        check("rst_frame", {32'h0, frame}, 64'h0);
        reset = 1'b0;
        step();

        // Latch group 1
        request_select = 6'b100101;
        step();
        request_select = 6'h3F;
        check("lat_v1", {63'h0, frame_valid}, 64'h1);
        check("lat_w0", {32'h0, frame}, 64'hAAAA0001);
        check("lat_stall1", {63'h0, stall}, 64'h0);
        check("lat_busy", {63'h0, busy}, 64'h1);
        step();
        check("lat_w1", {32'h0, frame}, 64'hBBBB0002);
        step();
        check("lat_w2", {32'h0, frame}, 64'hCCCC0003);
        check("lat_stall3", {63'h0, stall}, 64'h0);
        step();
        check("lat_eod", {63'h0, eod}, 64'h1);
        check("lat_eod_valid", {63'h0, frame_valid}, 64'h0);
        check("lat_eod_frame", {32'h0, frame}, 64'h0);
        step();
        check("lat_idle_busy", {63'h0, busy}, 64'h0);
        check("lat_idle_eod", {63'h0, eod}, 64'h0);

        // Latch group 7, last word
        request_select = 6'b101011;
        step();
        request_select = 6'h3F;
        check("g7_w0", {32'h0, frame}, 64'h07111111);
        step();
        step();
        check("g7_w2", {32'h0, frame}, 64'h07333333);
        step();
        step();

        // Register 7
        pipe_idle      = 1'b1;
        request_select = 6'b000111;
        step();
        request_select = 6'h3F;
        check("rf_stall1", {63'h0, stall}, 64'h1);
        check("rf_re1", {63'h0, rf_re}, 64'h0);
        step();
        check("rf_stall2", {63'h0, stall}, 64'h1);
        check("rf_re2", {63'h0, rf_re}, 64'h1);
        check("rf_addr2", {59'h0, rf_addr}, 64'h7);
        step();
        check("rf_stall3", {63'h0, stall}, 64'h1);
        check("rf_re3", {63'h0, rf_re}, 64'h0);
        check("rf_frame", {32'h0, frame}, 64'h12345678);
        check("rf_valid", {63'h0, frame_valid}, 64'h1);
        step();
        check("rf_eod", {63'h0, eod}, 64'h1);
        check("rf_eod_stall", {63'h0, stall}, 64'h0);
        step();

        // Grant wait on data memory
        pipe_idle      = 1'b0;
        mem_addr       = 16'h0040;
        request_select = 6'b100000;
        step();
        request_select = 6'h3F;
        for (int i = 0; i < 5; i++) begin
            check("gw_stall", {63'h0, stall}, 64'h1);
            check("gw_mem_re", {63'h0, mem_re}, 64'h0);
            if (i < 4) step();
        end
        pipe_idle = 1'b1;
        step();
        check("gw_mem_re_go", {63'h0, mem_re}, 64'h1);
        check("gw_space", {63'h0, mem_space}, 64'h0);
        check("gw_addr", {48'h0, mem_addr_out}, 64'h0040);
        step();
        check("gw_frame", {32'h0, frame}, 64'h00000040);
        step();
        check("gw_eod", {63'h0, eod}, 64'h1);
        step();

        // Instruction memory
        mem_addr       = 16'h1234;
        request_select = 6'b100001;
        step();
        request_select = 6'h3F;
        step();
        check("im_space", {63'h0, mem_space}, 64'h1);
        check("im_re", {63'h0, mem_re}, 64'h1);
        step();
        check("im_frame", {32'h0, frame}, 64'h00011234);
        step();
        step();

        // Second request during a latch transfer is dropped
        request_select = 6'b100101;
        step();
        request_select = 6'b100010;
        count_transfer(8);
        check("drop_frames", 64'(n_frames), 64'd2);
        check("drop_eods", 64'(n_eods), 64'd1);
        check("drop_busy", {63'h0, busy}, 64'h0);

        // Reset during GRANT
        pipe_idle      = 1'b0;
        request_select = 6'b000011;
        step();
        request_select = 6'h3F;
        check("rg_stall", {63'h0, stall}, 64'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rg_stall0", {63'h0, stall}, 64'h0);
        check("rg_busy0", {63'h0, busy}, 64'h0);
        check("rg_rf_addr0", {59'h0, rf_addr}, 64'h0);
        check("rg_frame0", {32'h0, frame}, 64'h0);
        count_transfer(4);
        check("rg_no_eod", 64'(n_eods), 64'd0);
        pc             = 32'hCAFE_F00D;
        request_select = 6'b100010;
        step();
        request_select = 6'h3F;
        check("pc_valid", {63'h0, frame_valid}, 64'h1);
        check("pc_frame", {32'h0, frame}, 64'hCAFEF00D);
        step();
        check("pc_eod", {63'h0, eod}, 64'h1);
        step();

        // Illegal code
        request_select = 6'b110000;
        step();
        request_select = 6'h3F;
        check("ill_busy", {63'h0, busy}, 64'h0);
        check("ill_valid", {63'h0, frame_valid}, 64'h0);
        step();
        check("ill_busy2", {63'h0, busy}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
